mainfsm: RTL

MAINFSM -- requirements
Module: mainfsm

---
 rtl/mainfsm_pkg.sv | 56 +++++
 rtl/mainfsm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mainfsm_pkg.sv
// Shared processor definitions: controller state codes, opcode classes and
// datapath select codes used by the controller and the datapath.
package mainfsm_pkg;

  // Controller state encoding. Codes 11..15 are illegal and recover to fetch.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StUnknown  = 4'd10
  } state_e;

  // Instruction class, Instr[27:26].
  localparam logic [1:0] OpDataProc = 2'b00;
  localparam logic [1:0] OpMemory   = 2'b01;
  localparam logic [1:0] OpBranch   = 2'b10;
  localparam logic [1:0] OpUnknown  = 2'b11;

  // Bit positions inside Funct.
  localparam int unsigned FunctImmBit  = 5;
  localparam int unsigned FunctLoadBit = 0;

  // ALU operand B select.
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBExtImm = 2'b01;
  localparam logic [1:0] SrcBFour   = 2'b10;

  // Result bus select.
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // Bundle of every controller output driven from the state.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '0;

endpackage

// File: rtl/mainfsm.sv
// Multicycle main controller FSM. Moore machine: every output is a function
// of the state register only.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] state
);

  // Held as a raw code so illegal values are representable and recoverable.
  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  // Funct[4:1] carry ALU function bits consumed by the ALU decoder, not here.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register with asynchronous reset into fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Op and Funct are only looked at in decode and memadr.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (Op)
          OpMemory:   state_d = StMemAdr;
          OpDataProc: state_d = Funct[FunctImmBit] ? StExecuteI : StExecuteR;
          OpBranch:   state_d = StBranch;
          default:    state_d = StUnknown;
        endcase
      end
      StMemAdr:   state_d = Funct[FunctLoadBit] ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StMemWb:    state_d = StFetch;
      StMemWr:    state_d = StFetch;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StUnknown:  state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Output decode; unlisted fields stay at their idle value of zero.
  always_comb begin
    ctrl = CtrlIdle;
    case (state_q)
      StFetch: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SrcBFour;
        ctrl.result_src = ResAluResult;
      end
      StDecode: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SrcBFour;
        ctrl.result_src = ResAluResult;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SrcBExtImm;
      end
      StMemRd: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = ResAluOut;
      end
      StMemWb: begin
        ctrl.result_src = ResData;
        ctrl.reg_w      = 1'b1;
      end
      StMemWr: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      StExecuteR: begin
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = 1'b1;
      end
      StExecuteI: begin
        ctrl.alu_src_b = SrcBExtImm;
        ctrl.alu_op    = 1'b1;
      end
      StAluWb: begin
        ctrl.result_src = ResAluOut;
        ctrl.reg_w      = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_b  = SrcBExtImm;
        ctrl.result_src = ResAluResult;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = CtrlIdle;
    endcase
  end

  assign IRWrite   = ctrl.ir_write;
  assign NextPC    = ctrl.next_pc;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign state     = state_q;

endmodule
